// File: rtl/addsub_acc.sv
// Registered add/subtract/accumulate unit with carry/overflow/zero flags and optional signed saturation; latency 1.
// Single output stage: in_ready = !out_valid || out_ready, so it sustains 1 op/cycle and stalls while the consumer holds off.
module addsub_acc #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dataa,
    input  logic [DW-1:0] datab,
    input  logic [1:0]    op,
    input  logic          sat_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          ovf,
    output logic          zero,
    output logic          ovf_sticky,
    output logic [DW-1:0] acc
);

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};

    logic          accept;
    logic [DW:0]   sum;
    logic          nxt_carry;
    logic          nxt_ovf;
    logic [DW-1:0] nxt_res;
    logic          lhs_neg;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum       = '0;
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        lhs_neg   = dataa[DW-1];
        case (op)
            OP_SUB: begin
                sum       = {1'b0, dataa} + {1'b0, ~datab} + {{DW{1'b0}}, 1'b1};
                nxt_carry = sum[DW];
                nxt_ovf   = (dataa[DW-1] != datab[DW-1]) && (sum[DW-1] != dataa[DW-1]);
            end
            OP_ADD: begin
                sum       = {1'b0, dataa} + {1'b0, datab};
                nxt_carry = sum[DW];
                nxt_ovf   = (dataa[DW-1] == datab[DW-1]) && (sum[DW-1] != dataa[DW-1]);
            end
            OP_ACC: begin
                sum       = {1'b0, acc} + {1'b0, dataa};
                nxt_carry = sum[DW];
                nxt_ovf   = (acc[DW-1] == dataa[DW-1]) && (sum[DW-1] != acc[DW-1]);
                lhs_neg   = acc[DW-1];
            end
            default: begin
                sum = {1'b0, dataa};
            end
        endcase
        // On overflow the true value's sign is that of the left-hand operand.
        if (sat_en && nxt_ovf)
            nxt_res = lhs_neg ? NEG_MAX : POS_MAX;
        else
            nxt_res = sum[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
            ovf_sticky <= 1'b0;
            acc        <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= nxt_res;
            carry     <= nxt_carry;
            ovf       <= nxt_ovf;
            zero      <= (nxt_res == '0);
            if (op == OP_LOAD) begin
                acc        <= dataa;
                ovf_sticky <= 1'b0;
            end else begin
                ovf_sticky <= ovf_sticky | nxt_ovf;
                if (op == OP_ACC)
                    acc <= nxt_res;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_acc.sv
// Bench for addsub_acc: directed scenarios plus randomized ops checked against an integer-arithmetic reference model.
module tb_addsub_acc;

    localparam int DW   = 8;
    localparam int MOD  = 2 ** DW;
    localparam int SMAX = 2 ** (DW - 1) - 1;
    localparam int SMIN = -(2 ** (DW - 1));

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dataa = '0;
    logic [DW-1:0] datab = '0;
    logic [1:0]    op = 2'b00;
    logic          sat_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] result;
    logic          carry;
    logic          ovf;
    logic          zero;
    logic          ovf_sticky;
    logic [DW-1:0] acc;

    int n_chk  = 0;
    int n_fail = 0;

    int m_res, m_carry, m_ovf, m_acc, m_sticky;

    addsub_acc #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .op(op), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .ovf(ovf), .zero(zero), .ovf_sticky(ovf_sticky), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_s(input int v);
        return (v > SMAX) ? v - MOD : v;
    endfunction

    // Reference: exact signed value, then clamp or wrap.
    task automatic model_apply(input logic [1:0] o, input int a, input int b, input logic s);
        int tv;
        if (o == 2'b11) begin
            m_res = a; m_carry = 0; m_ovf = 0; m_acc = a; m_sticky = 0;
            return;
        end
        case (o)
            2'b00: begin tv = to_s(a) - to_s(b);     m_carry = (a >= b) ? 1 : 0; end
            2'b01: begin tv = to_s(a) + to_s(b);     m_carry = (a + b >= MOD) ? 1 : 0; end
            default: begin tv = to_s(m_acc) + to_s(a); m_carry = (m_acc + a >= MOD) ? 1 : 0; end
        endcase
        m_ovf = (tv > SMAX || tv < SMIN) ? 1 : 0;
        if (s && m_ovf) m_res = (tv > 0) ? SMAX : (MOD + SMIN);
        else            m_res = tv & (MOD - 1);
        if (o == 2'b10) m_acc = m_res;
        m_sticky = m_sticky | m_ovf;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, int'(out_valid), 1);
        chk({tag, ".result"}, int'(result), m_res);
        chk({tag, ".carry"}, int'(carry), m_carry);
        chk({tag, ".ovf"}, int'(ovf), m_ovf);
        chk({tag, ".zero"}, int'(zero), (m_res == 0) ? 1 : 0);
        chk({tag, ".sticky"}, int'(ovf_sticky), m_sticky);
        chk({tag, ".acc"}, int'(acc), m_acc);
    endtask

    // Presents one op, waits (bounded) for acceptance, then checks the registered output.
    task automatic do_op(input string tag, input logic [1:0] o, input int a, input int b, input logic s);
        int waited = 0;
        op = o; dataa = a[DW-1:0]; datab = b[DW-1:0]; sat_en = s; in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk({tag, ".accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_apply(o, a, b, s);
        check_outputs(tag);
    endtask

    initial begin
        m_res = 0; m_carry = 0; m_ovf = 0; m_acc = 0; m_sticky = 0;
        #12;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.result", int'(result), 0);
        chk("rst.acc", int'(acc), 0);
        chk("rst.sticky", int'(ovf_sticky), 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // ADD overflow, wrap then saturate
        do_op("add_wrap", 2'b01, 'h7F, 'h01, 1'b0);
        chk("add_wrap.const", int'(result), 'h80);
        do_op("add_sat", 2'b01, 'h7F, 'h01, 1'b1);
        chk("add_sat.const", int'(result), 'h7F);
        chk("add_sat.sticky_const", int'(ovf_sticky), 1);

        // SUB borrow and zero
        do_op("sub_neg", 2'b00, 'h05, 'h07, 1'b0);
        chk("sub_neg.const", int'(result), 'hFE);
        do_op("sub_zero", 2'b00, 'h33, 'h33, 1'b0);
        chk("sub_zero.carry_const", int'(carry), 1);

        // Back-to-back LOAD/ACC/ACC
        do_op("load10", 2'b11, 'h10, 'h00, 1'b0);
        chk("load10.const", int'(result), 'h10);
        do_op("acc20", 2'b10, 'h20, 'h00, 1'b0);
        chk("acc20.const", int'(result), 'h30);
        do_op("accF0", 2'b10, 'hF0, 'h00, 1'b0);
        chk("accF0.const", int'(acc), 'h20);

        // Negative saturation on ACC, then LOAD clears sticky
        do_op("load80", 2'b11, 'h80, 'h00, 1'b0);
        do_op("accFF_sat", 2'b10, 'hFF, 'h00, 1'b1);
        chk("accFF_sat.const", int'(result), 'h80);
        do_op("load00", 2'b11, 'h00, 'h00, 1'b0);
        chk("load00.sticky_const", int'(ovf_sticky), 0);

        // Backpressure: result held, op queued until out_ready returns
        do_op("pre_stall", 2'b01, 'h10, 'h20, 1'b0);
        out_ready = 1'b0;
        op = 2'b01; dataa = 'h01; datab = 'h02; sat_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
            chk("stall.result_hold", int'(result), 'h30);
            chk("stall.out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.in_ready_release", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_apply(2'b01, 'h01, 'h02, 1'b0);
        check_outputs("stall_release");
        @(posedge clk); #1;
        chk("stall.no_dup", int'(out_valid), 0);

        // Asynchronous reset mid-cycle with a pending output
        do_op("load55", 2'b11, 'h55, 'h00, 1'b0);
        out_ready = 1'b0;
        #2; reset = 1'b1; #1;
        chk("arst.out_valid", int'(out_valid), 0);
        chk("arst.acc", int'(acc), 0);
        chk("arst.result", int'(result), 0);
        chk("arst.flags", int'({carry, ovf, zero, ovf_sticky}), 0);
        #1; reset = 1'b0;
        m_res = 0; m_carry = 0; m_ovf = 0; m_acc = 0; m_sticky = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_op("post_rst", 2'b01, 'h01, 'h01, 1'b0);

        // Randomized ops with occasional idle cycles
        for (int i = 0; i < 300; i++) begin
            do_op("rand", 2'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)),
                  int'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("rand.idle_valid", int'(out_valid), 0);
                chk("rand.idle_acc", int'(acc), m_acc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
